// File: rtl/multiword_add_sequencer_if.sv
// Bus bundle for multiword_add_sequencer: operand/result handshakes plus the adder stage ports.
// OVERFLOW_FLAG_EN adds the out_ovf result flag.
interface multiword_add_sequencer_if #(
  parameter int unsigned W     = 16,
  parameter int unsigned WORDS = 4
);
  localparam int unsigned TW = W * WORDS;

  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] in_a;
  logic [TW-1:0] in_b;
  logic          in_cin;
  logic [W-1:0]  add_a;
  logic [W-1:0]  add_b;
  logic          add_cin;
  logic [W-1:0]  add_sum;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_sum;
  logic          out_cout;
`ifdef OVERFLOW_FLAG_EN
  logic          out_ovf;
`endif

  // Sequencer side
  modport slave (
    input  in_valid, in_a, in_b, in_cin, add_sum, out_ready,
    output
`ifdef OVERFLOW_FLAG_EN
           out_ovf,
`endif
           in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout
  );

  // Environment side: operand source, adder stage and result consumer
  modport master (
    output in_valid, in_a, in_b, in_cin, add_sum, out_ready,
    input
`ifdef OVERFLOW_FLAG_EN
           out_ovf,
`endif
           in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout
  );
endinterface

// File: rtl/multiword_add_sequencer.sv
// Sequences a W*WORDS-bit addition through a W-bit adder one word per clock, chaining carries.
// OVERFLOW_FLAG_EN adds out_ovf (signed overflow of the top word).
module multiword_add_sequencer #(
  parameter int unsigned W     = 16,
  parameter int unsigned WORDS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  multiword_add_sequencer_if.slave    bus
);
  localparam int unsigned TW = W * WORDS;
  localparam int unsigned KW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] a_q, a_d;
  logic [TW-1:0] b_q, b_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  add_a_q, add_a_d;
  logic [W-1:0]  add_b_q, add_b_d;
  logic          add_cin_q, add_cin_d;
  logic [TW-1:0] out_sum_q, out_sum_d;
  logic          out_cout_q, out_cout_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;
  logic          carry_c;
`ifdef OVERFLOW_FLAG_EN
  logic          out_ovf_q, out_ovf_d;
`endif

  // Carry out of the current word, rebuilt from the operand and sum MSBs
  assign carry_c = (add_a_q[W-1] & add_b_q[W-1]) |
                   ((add_a_q[W-1] | add_b_q[W-1]) & ~bus.add_sum[W-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      k_q         <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef OVERFLOW_FLAG_EN
      out_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      k_q         <= k_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef OVERFLOW_FLAG_EN
      out_ovf_q   <= out_ovf_d;
`endif
    end
  end

  // Operand words are pre-shifted so the next word is always at the bottom of a_q/b_q
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    k_d         = k_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_cin_d   = add_cin_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
`ifdef OVERFLOW_FLAG_EN
    out_ovf_d   = out_ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_d        = TW'(bus.in_a >> W);
          b_d        = TW'(bus.in_b >> W);
          add_a_d    = bus.in_a[W-1:0];
          add_b_d    = bus.in_b[W-1:0];
          add_cin_d  = bus.in_cin;
          k_d        = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        out_sum_d[int'(k_q)*W +: W] = bus.add_sum;
        if (k_q == KW'(WORDS - 1)) begin
          out_cout_d  = carry_c;
`ifdef OVERFLOW_FLAG_EN
          out_ovf_d   = add_a_q[W-1] ^ add_b_q[W-1] ^ bus.add_sum[W-1] ^ carry_c;
`endif
          add_a_d     = '0;
          add_b_d     = '0;
          add_cin_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          k_d       = k_q + KW'(1);
          add_a_d   = a_q[W-1:0];
          add_b_d   = b_q[W-1:0];
          add_cin_d = carry_c;
          a_d       = TW'(a_q >> W);
          b_d       = TW'(b_q >> W);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.add_cin   = add_cin_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cout  = out_cout_q;
`ifdef OVERFLOW_FLAG_EN
  assign bus.out_ovf   = out_ovf_q;
`endif
endmodule
